// File: rtl/raster_pkg.sv
// Shared types and default geometry for the raster scan controller.
// The scan FSM encoding is kept here so monitors can decode it too.
package raster_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam int DEF_H_MAX = 15;
    localparam int DEF_V_MAX = 15;
    localparam int DEF_FCW   = 8;

    // Last pixel of a frame: both axes sitting on their maxima.
    function automatic logic is_frame_end(input logic x_at_max, input logic y_at_max);
        return x_at_max & y_at_max;
    endfunction

endpackage

// File: rtl/raster_scan_ctrl_axis_counter.sv
// Modulo-(MAX+1) coordinate counter; advances on inc and wraps at MAX, not at 2^N.
module axis_counter #(
    parameter int N   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [N-1:0] count,
    output logic         at_max
);

    localparam logic [N-1:0] MAX_C = N'(MAX);

    logic [N-1:0] count_reg;
    logic [N-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc) begin
            count_next = (count_reg == MAX_C) ? '0 : count_reg + N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count  = count_reg;
    assign at_max = (count_reg == MAX_C);

endmodule

// File: rtl/raster_scan_ctrl.sv
// Raster (x, y) coordinate generator with ready/valid output, single-shot or
// continuous frames, line/frame end flags and a completed-frame counter.
module raster_scan_ctrl
    import raster_pkg::*;
#(
    parameter int H_MAX = DEF_H_MAX,
    parameter int V_MAX = DEF_V_MAX,
    parameter int XW    = $clog2(H_MAX + 1),
    parameter int YW    = $clog2(V_MAX + 1),
    parameter int FCW   = DEF_FCW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           clear,
    input  logic           continuous,
    input  logic           ready,
    output logic           valid,
    output logic [XW-1:0]  x,
    output logic [YW-1:0]  y,
    output logic           line_end,
    output logic           frame_end,
    output logic           busy,
    output logic           done,
    output logic [FCW-1:0] frame_count
);

    scan_state_t    state_reg;
    logic           valid_reg;
    logic           done_reg;
    logic [FCW-1:0] frame_count_reg;

    logic beat;
    logic x_at_max;
    logic y_at_max;
    logic last_beat;

    assign beat      = valid_reg & ready;
    assign last_beat = beat & is_frame_end(x_at_max, y_at_max);

    // The vertical axis steps on the horizontal wrap, in the same clock domain.
    axis_counter #(
        .N   (XW),
        .MAX (H_MAX)
    ) u_h_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .inc    (beat),
        .count  (x),
        .at_max (x_at_max)
    );

    axis_counter #(
        .N   (YW),
        .MAX (V_MAX)
    ) u_v_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .inc    (beat & x_at_max),
        .count  (y),
        .at_max (y_at_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            valid_reg       <= 1'b0;
            done_reg        <= 1'b0;
            frame_count_reg <= '0;
        end else if (clear) begin
            // Abort keeps the completed-frame tally intact.
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= SCAN;
                        valid_reg <= 1'b1;
                        done_reg  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (last_beat) begin
                        frame_count_reg <= frame_count_reg + FCW'(1);
                        // continuous only matters on the frame-end beat
                        if (!continuous) begin
                            state_reg <= DONE;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign valid       = valid_reg;
    assign busy        = valid_reg;
    assign done        = done_reg;
    assign frame_count = frame_count_reg;
    assign line_end    = valid_reg & x_at_max;
    assign frame_end   = valid_reg & is_frame_end(x_at_max, y_at_max);

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Directed bench: a 4x3 instance for the protocol cases and a default 16x16
// instance with a 2-bit frame counter for wrap behaviour.
module tb_raster_scan_ctrl;

    logic clk = 1'b0;
    logic reset, start, clear, continuous, ready;

    logic       valid, line_end, frame_end, busy, done;
    logic [1:0] x;
    logic [1:0] y;
    logic [7:0] frame_count;

    logic       valid_d, line_end_d, frame_end_d, busy_d, done_d;
    logic [3:0] x_d, y_d;
    logic [1:0] frame_count_d;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    raster_scan_ctrl #(.H_MAX(3), .V_MAX(2), .FCW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .continuous(continuous), .ready(ready), .valid(valid), .x(x), .y(y),
        .line_end(line_end), .frame_end(frame_end), .busy(busy), .done(done),
        .frame_count(frame_count)
    );

    raster_scan_ctrl #(.FCW(2)) dut_d (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .continuous(continuous), .ready(ready), .valid(valid_d), .x(x_d), .y(y_d),
        .line_end(line_end_d), .frame_end(frame_end_d), .busy(busy_d), .done(done_d),
        .frame_count(frame_count_d)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag, input int fc, input logic exp_done);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_x"}, 32'(x), 32'd0);
        check({tag, "_y"}, 32'(y), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_line_end"}, 32'(line_end), 32'd0);
        check({tag, "_frame_end"}, 32'(frame_end), 32'd0);
        check({tag, "_fc"}, 32'(frame_count), 32'(fc));
    endtask

    task automatic check_pixel(input string tag, input int idx, input int fc);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_x"}, 32'(x), 32'(idx % 4));
        check({tag, "_y"}, 32'(y), 32'(idx / 4));
        check({tag, "_line_end"}, 32'(line_end), 32'(idx % 4 == 3));
        check({tag, "_frame_end"}, 32'(frame_end), 32'(idx == 11));
        check({tag, "_fc"}, 32'(frame_count), 32'(fc));
    endtask

    initial begin
        int idx;
        int cyc;
        logic r;

        reset = 1'b1; start = 1'b0; clear = 1'b0; continuous = 1'b0; ready = 1'b1;
        @(negedge clk);
        tick();
        reset = 1'b0;

        // Reset state of both instances
        check_idle("rst", 0, 1'b0);
        check("rst_d_valid", 32'(valid_d), 32'd0);
        check("rst_d_fc", 32'(frame_count_d), 32'd0);
        tick();
        check_idle("rst_hold", 0, 1'b0);

        // Single-shot frame, ready held high
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check_pixel($sformatf("single_%0d", i), i, 0);
            tick();
        end
        check_idle("single_end", 1, 1'b1);
        tick();
        check_idle("single_done_hold", 1, 1'b1);

        // Continuous: no bubble between frames, drop continuous in frame 3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("rst2", 0, 1'b0);
        continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 36; n++) begin
            check_pixel($sformatf("cont_%0d", n), n % 12, n / 12);
            check($sformatf("cont_busy_%0d", n), 32'(busy), 32'd1);
            if (n == 30) continuous = 1'b0;
            tick();
        end
        check_idle("cont_end", 3, 1'b1);

        // Pseudo-random stalls: same raster order, nothing skipped or repeated
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 12 && cyc < 200) begin
            check_pixel($sformatf("stall_c%0d", cyc), idx, 3);
            r = 1'($urandom_range(0, 1));
            ready = r;
            tick();
            if (r) idx++;
            cyc++;
        end
        check("stall_timeout", 32'(idx), 32'd12);
        ready = 1'b1;
        check_idle("stall_end", 4, 1'b1);

        // clear at (2,1), then clear together with start
        continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("clr_at_x", 32'(x), 32'd2);
        check("clr_at_y", 32'(y), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_idle("clr", 4, 1'b0);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check_idle("clr_start", 4, 1'b0);
        tick();
        check_idle("clr_start_hold", 4, 1'b0);

        // One-cycle reset mid-scan, then restart
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("mid_x", 32'(x), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("mid_rst", 0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_pixel("restart_0", 0, 0);
        tick();
        check_pixel("restart_1", 1, 0);

        // Default 16x16 instance with 2-bit frame counter
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("def_rst_fc", 32'(frame_count_d), 32'd0);
        check("def_rst_valid", 32'(valid_d), 32'd0);
        continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 1024; n++) begin
            if (n % 64 == 0 || n % 256 == 255) begin
                check($sformatf("def_x_%0d", n), 32'(x_d), 32'(n % 16));
                check($sformatf("def_y_%0d", n), 32'(y_d), 32'((n / 16) % 16));
                check($sformatf("def_fc_%0d", n), 32'(frame_count_d), 32'((n / 256) % 4));
                check($sformatf("def_fe_%0d", n), 32'(frame_end_d), 32'(n % 256 == 255));
                check($sformatf("def_le_%0d", n), 32'(line_end_d), 32'(n % 16 == 15));
            end
            tick();
        end
        check("def_wrap_fc", 32'(frame_count_d), 32'd0);
        check("def_wrap_valid", 32'(valid_d), 32'd1);
        check("def_wrap_x", 32'(x_d), 32'd0);
        check("def_wrap_y", 32'(y_d), 32'd0);
        check("def_wrap_busy", 32'(busy_d), 32'd1);
        check("def_wrap_done", 32'(done_d), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/raster_scan_ctrl.md
Name: raster_scan_ctrl

Overview:
- Parametrised, single-clock successor to the 4-bit image controller: generates raster (x, y) pixel coordinates for an H x V image.
- Adds a ready/valid output handshake, single-shot and continuous frame modes, line/frame end flags and a completed-frame counter.
- The vertical axis advances on a horizontal-wrap enable, never on a derived clock.
- Sits between top-level pushbutton/control logic and downstream pixel consumers (display/UART formatter).

Parameters:
- H_MAX, 15, last horizontal coordinate (inclusive); line length = H_MAX+1, H_MAX >= 1
- V_MAX, 15, last vertical coordinate (inclusive); frame height = V_MAX+1, V_MAX >= 1
- XW, $clog2(H_MAX+1), width of x
- YW, $clog2(V_MAX+1), width of y
- FCW, 8, width of completed-frame counter

Ports:
- clk  input  1  system clock; all state on posedge clk
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a frame from IDLE or DONE
- clear  input  1  synchronous abort: return to IDLE, zero coordinates
- continuous  input  1  1 = rescan after the last pixel, 0 = stop after the current frame
- ready  input  1  downstream accepts current coordinate
- valid  output  1  x/y hold a live coordinate
- x  output  XW  horizontal coordinate
- y  output  YW  vertical coordinate
- line_end  output  1  valid & (x == H_MAX)
- frame_end  output  1  valid & (x == H_MAX) & (y == V_MAX)
- busy  output  1  state == SCAN
- done  output  1  state == DONE
- frame_count  output  FCW  completed frames, wraps at 2^FCW-1 -> 0

Behaviour:
- Reset: state IDLE; x = 0; y = 0; frame_count = 0; valid, busy, done, line_end, frame_end all 0.
- Priority each cycle: reset > clear > normal operation.
- Beat: valid & ready. x/y/state change only on a beat, except for start, clear and reset.
- IDLE:
  - valid = 0.
  - start = 1: SCAN on the next cycle with x = 0, y = 0, valid = 1. One-cycle latency from start to first valid.
- SCAN:
  - valid = 1.
  - ready = 0: x and y hold indefinitely (stall).
  - Beat with x < H_MAX: x + 1.
  - Beat with x == H_MAX, y < V_MAX: x = 0, y + 1.
  - Beat with x == H_MAX, y == V_MAX (frame end): frame_count + 1; x = 0, y = 0.
    - continuous = 1: stay in SCAN, valid stays 1 with no bubble.
    - continuous = 0: go to DONE, valid = 0.
  - continuous is sampled only on the frame-end beat. Deasserting it mid-frame finishes the current frame and then stops.
  - start is ignored in SCAN.
- DONE:
  - done = 1, held until start or clear; x = 0, y = 0, valid = 0.
  - start: SCAN next cycle at (0,0).
- clear:
  - Next state IDLE; x = 0, y = 0, valid = 0.
  - frame_count is preserved; only reset zeroes it.
  - clear & start in the same cycle: clear wins, state IDLE.
- Flags: line_end and frame_end are combinational from the registered state; they are 0 whenever valid = 0.
- Widths: x and y never exceed H_MAX / V_MAX. For non-power-of-two maxima, wrap occurs at the maximum, not at 2^W.

Decomposition:
- Package raster_pkg:
  - state enum typedef {IDLE, SCAN, DONE} (2-bit)
  - default H_MAX / V_MAX constants
- Sub-module axis_counter:
  - Parameters N and MAX; inputs clk, reset, clear, inc; outputs count, at_max.
  - Wraps to 0 on inc when at_max; synchronous reset and clear.
- Instances:
  - Horizontal: inc = beat.
  - Vertical: inc = beat & x_at_max, same clk.
  - Top-level FSM and frame_count live in raster_scan_ctrl.

Test Plan:
- H_MAX=3, V_MAX=2, continuous=0, ready=1, 1-cycle start -> 12 valid beats (0,0)..(3,2) in raster order, line_end on x=3, frame_end only at (3,2), then done=1, valid=0, frame_count=1.
- Same config, continuous=1 for 30 beats -> (0,0) follows (3,2) with no bubble; frame_count=2 after beat 24; drop continuous mid-frame 3 -> done after (3,2) of frame 3, frame_count=3.
- ready toggled pseudo-randomly -> coordinates stable whenever ready=0; sequence identical to the ready=1 run, no skipped or duplicated pixel.
- clear at (2,1) -> next cycle IDLE, x=y=0, valid=0, frame_count unchanged; clear+start together -> stays IDLE.
- reset asserted mid-SCAN for 1 cycle -> all outputs at reset values next cycle, frame_count=0; start still works afterwards.
- Defaults H_MAX=V_MAX=15, FCW=2 -> 256 beats per frame; frame_count wraps 3->0 on frame 4.
